// File: rtl/wb_timer_if.sv
// Wishbone-style 16-bit bus interface shared by master and the wb_timer slave.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [15:0] dat_m2s;
  logic [15:0] dat_s2m;
  logic        ack;

  modport slave (
    input  cyc, stb, we, adr, dat_m2s,
    output dat_s2m, ack
  );

  modport master (
    output cyc, stb, we, adr, dat_m2s,
    input  dat_s2m, ack
  );
endinterface

// File: rtl/wb_timer.sv
// Bus-mapped 16-bit timer: CTRL/COUNT/COMPARE/STATUS behind a wait-state bus FSM.
// Define WB_TIMER_IRQ_EN to build the IRQEN control bit and the irq output.
module wb_timer #(
  parameter logic [15:0] BASE_ADR    = 16'h7FFC,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic   clk,
  input  logic   reset,
  if_wb.slave    wb,
  output logic   irq
);

`ifdef WB_TIMER_IRQ_EN
  localparam bit IrqSupported = 1'b1;
`else
  localparam bit IrqSupported = 1'b0;
`endif

  localparam bit          NoWait      = (WAIT_STATES == 0);
  localparam int unsigned WaitLastInt = NoWait ? 0 : WAIT_STATES - 1;
  localparam logic [2:0]  WaitLast    = 3'(WaitLastInt);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e      state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        en_q, en_d, reload_q, reload_d, irqen_q, irqen_d;
  logic [7:0]  presc_q, presc_d, pre_q, pre_d;
  logic [15:0] count_q, count_d, compare_q, compare_d;
  logic        match_q, match_d, irq_q, irq_d;

  logic        sel, commit, tick, match_set;
  logic        wr_ctrl, wr_count, wr_cmp, wr_status;
  logic [1:0]  idx;
  logic [15:0] rmux;

  assign sel = wb.cyc & wb.stb & (wb.adr[15:2] == BASE_ADR[15:2]);
  assign idx = wb.adr[1:0];

  // Bus FSM; commit marks the edge that enters StAck.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    commit     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel) begin
          if (NoWait) begin
            state_d = StAck;
            commit  = 1'b1;
          end else begin
            state_d    = StWait;
            wait_cnt_d = 3'd0;
          end
        end
      end
      StWait: begin
        if (!(wb.cyc && wb.stb)) begin
          state_d    = StIdle;
          wait_cnt_d = 3'd0;
        end else if (wait_cnt_q == WaitLast) begin
          state_d    = StAck;
          commit     = 1'b1;
          wait_cnt_d = 3'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign wr_ctrl   = commit & wb.we & (idx == 2'd0);
  assign wr_count  = commit & wb.we & (idx == 2'd1);
  assign wr_cmp    = commit & wb.we & (idx == 2'd2);
  assign wr_status = commit & wb.we & (idx == 2'd3);

  always_comb begin
    rmux = 16'h0;
    unique case (idx)
      2'd0: rmux = {presc_q, 5'b0, irqen_q, reload_q, en_q};
      2'd1: rmux = count_q;
      2'd2: rmux = compare_q;
      2'd3: rmux = {15'b0, match_q};
      default: rmux = 16'h0;
    endcase
  end

  // Read data only lives for the ack cycle, so it is zero otherwise.
  assign rdata_d = (commit && !wb.we) ? rmux : 16'h0;

  assign tick = en_q && (pre_q == presc_q);

  // Timer datapath; bus writes are applied last so they win over tick updates.
  always_comb begin
    en_d      = en_q;
    reload_d  = reload_q;
    irqen_d   = irqen_q;
    presc_d   = presc_q;
    pre_d     = pre_q;
    count_d   = count_q;
    compare_d = compare_q;
    match_set = 1'b0;

    if (en_q) pre_d = tick ? 8'd0 : pre_q + 8'd1;

    if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        if (reload_q) count_d = 16'h0;
        else          en_d    = 1'b0;
      end else begin
        count_d = count_q + 16'd1;
      end
    end

    if (wr_ctrl) begin
      en_d     = wb.dat_m2s[0];
      reload_d = wb.dat_m2s[1];
      irqen_d  = wb.dat_m2s[2] & IrqSupported;
      presc_d  = wb.dat_m2s[15:8];
    end
    if (wr_count) begin
      count_d = wb.dat_m2s;
      pre_d   = 8'd0;
    end
    if (wr_cmp) compare_d = wb.dat_m2s;
  end

  assign match_d = match_set | (match_q & ~(wr_status & wb.dat_m2s[0]));
  assign irq_d   = match_q & irqen_q & IrqSupported;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 3'd0;
      rdata_q    <= 16'h0;
      en_q       <= 1'b0;
      reload_q   <= 1'b0;
      irqen_q    <= 1'b0;
      presc_q    <= 8'd0;
      pre_q      <= 8'd0;
      count_q    <= 16'h0;
      compare_q  <= 16'hFFFF;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      en_q       <= en_d;
      reload_q   <= reload_d;
      irqen_q    <= irqen_d;
      presc_q    <= presc_d;
      pre_q      <= pre_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      irq_q      <= irq_d;
    end
  end

  assign wb.ack     = (state_q == StAck);
  assign wb.dat_s2m = rdata_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: one instance with no wait states, one with two.
module tb_wb_timer;

`ifdef WB_TIMER_IRQ_EN
  localparam bit IrqBuilt = 1'b1;
`else
  localparam bit IrqBuilt = 1'b0;
`endif
  localparam logic [15:0] Base = 16'h7FFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tgt = 1'b0;
  logic        m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [15:0] m_adr = 16'h0, m_dat = 16'h0;
  logic        irq0, irq2, s_ack;
  logic [15:0] s_dat;
  int          n_vec = 0;
  int          n_err = 0;

  if_wb wb0 ();
  if_wb wb2 ();

  assign wb0.cyc     = m_cyc & ~tgt;
  assign wb0.stb     = m_stb & ~tgt;
  assign wb0.we      = m_we;
  assign wb0.adr     = m_adr;
  assign wb0.dat_m2s = m_dat;
  assign wb2.cyc     = m_cyc & tgt;
  assign wb2.stb     = m_stb & tgt;
  assign wb2.we      = m_we;
  assign wb2.adr     = m_adr;
  assign wb2.dat_m2s = m_dat;
  assign s_ack       = tgt ? wb2.ack : wb0.ack;
  assign s_dat       = tgt ? wb2.dat_s2m : wb0.dat_s2m;

  wb_timer #(.BASE_ADR(Base), .WAIT_STATES(0)) u_ws0 (.clk(clk), .reset(reset), .wb(wb0), .irq(irq0));
  wb_timer #(.BASE_ADR(Base), .WAIT_STATES(2)) u_ws2 (.clk(clk), .reset(reset), .wb(wb2), .irq(irq2));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge, returns at the negedge where ack is seen.
  task automatic bus_xfer(input bit t, input bit w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int n);
    tgt = t; m_cyc = 1'b1; m_stb = 1'b1; m_we = w; m_adr = a; m_dat = d;
    n = 0; rd = 16'h0;
    do begin
      @(posedge clk); @(negedge clk); n++;
    end while (!s_ack && n < 20);
    if (s_ack) rd = s_dat;
    else check_eq("ack_timeout", 16'd0, 16'd1);
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
  endtask

  task automatic wr(input bit t, input logic [1:0] r, input logic [15:0] d);
    logic [15:0] rd;
    int n;
    bus_xfer(t, 1'b1, Base + 16'(r), d, rd, n);
  endtask

  task automatic rd_chk(input string tag, input bit t, input logic [1:0] r, input logic [15:0] e);
    logic [15:0] rd;
    int n;
    bus_xfer(t, 1'b0, Base + 16'(r), 16'h0, rd, n);
    check_eq(tag, rd, e);
  endtask

  initial begin
    logic [15:0] rd;
    int n;
    #2;
    check_eq("rst_ack", 16'(wb0.ack), 16'h0);
    check_eq("rst_dat", wb0.dat_s2m, 16'h0);
    check_eq("rst_irq", 16'(irq0), 16'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    rd_chk("rst_ctrl", 1'b0, 2'd0, 16'h0000);
    rd_chk("rst_count", 1'b0, 2'd1, 16'h0000);
    rd_chk("rst_cmp", 1'b0, 2'd2, 16'hFFFF);
    rd_chk("rst_status", 1'b0, 2'd3, 16'h0000);

    // CTRL reserved bits and build-dependent IRQEN
    wr(1'b0, 2'd0, 16'hABFE);
    rd_chk("ctrl_mask", 1'b0, 2'd0, IrqBuilt ? 16'hAB06 : 16'hAB02);
    wr(1'b0, 2'd0, 16'h0000);

    // Zero wait states: single-cycle ack one cycle after select
    @(negedge clk);
    bus_xfer(1'b0, 1'b1, 16'h7FFE, 16'h0003, rd, n);
    check_eq("ws0_wr_lat", 16'(n), 16'd1);
    @(negedge clk);
    check_eq("ws0_ack_pulse", 16'(s_ack), 16'h0);
    bus_xfer(1'b0, 1'b0, 16'h7FFE, 16'h0, rd, n);
    check_eq("ws0_rd_lat", 16'(n), 16'd1);
    check_eq("ws0_rd_cmp", rd, 16'h0003);

    // Address outside the block is ignored
    @(negedge clk);
    tgt = 1'b0; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 16'h7FFA; m_dat = 16'h9999;
    repeat (3) @(negedge clk);
    check_eq("decode_no_ack", 16'(s_ack), 16'h0);
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    @(negedge clk);
    rd_chk("decode_no_wr", 1'b0, 2'd2, 16'h0003);

    // Match with reload, irq, write-1-clear
    wr(1'b0, 2'd2, 16'h0002);
    @(negedge clk);
    wr(1'b0, 2'd0, 16'h0107);                 // commit edge E0, now at N0
    repeat (5) @(negedge clk);                // N5
    check_eq("m_irq_pre", 16'(irq0), 16'h0);
    rd_chk("m_status_e6", 1'b0, 2'd3, 16'h0000);   // samples before E6
    rd_chk("m_count_rld", 1'b0, 2'd1, 16'h0000);   // E8, after reload at E6
    check_eq("m_irq_set", 16'(irq0), 16'(IrqBuilt));
    rd_chk("m_status_set", 1'b0, 2'd3, 16'h0001);  // E10
    @(negedge clk); @(negedge clk);           // N12
    wr(1'b0, 2'd3, 16'h0001);                 // clear at E13
    @(negedge clk);                           // N14
    check_eq("m_irq_clr", 16'(irq0), 16'h0);
    rd_chk("m_status_clr", 1'b0, 2'd3, 16'h0000);
    wr(1'b0, 2'd0, 16'h0000);

    // Wrap 0xFFFF -> 0x0000 without match
    @(negedge clk);
    wr(1'b0, 2'd1, 16'hFFFF);
    @(negedge clk);
    wr(1'b0, 2'd2, 16'h0005);
    @(negedge clk);
    wr(1'b0, 2'd0, 16'h0001);
    rd_chk("wrap_count", 1'b0, 2'd1, 16'h0000);
    rd_chk("wrap_nomatch", 1'b0, 2'd3, 16'h0000);
    wr(1'b0, 2'd0, 16'h0000);

    // RELOAD=0: stop at COMPARE and clear EN
    @(negedge clk);
    wr(1'b0, 2'd1, 16'h0000);
    @(negedge clk);
    wr(1'b0, 2'd2, 16'h0002);
    @(negedge clk);
    wr(1'b0, 2'd0, 16'h0001);
    repeat (4) @(negedge clk);
    rd_chk("stop_ctrl", 1'b0, 2'd0, 16'h0000);
    rd_chk("stop_count", 1'b0, 2'd1, 16'h0002);
    rd_chk("stop_status", 1'b0, 2'd3, 16'h0001);
    wr(1'b0, 2'd3, 16'h0000);
    rd_chk("w0_no_effect", 1'b0, 2'd3, 16'h0001);
    wr(1'b0, 2'd3, 16'h0001);
    rd_chk("w1_clear", 1'b0, 2'd3, 16'h0000);

    // COUNT write coinciding with a tick wins
    wr(1'b0, 2'd2, 16'h0100);
    @(negedge clk);
    wr(1'b0, 2'd1, 16'h0000);
    @(negedge clk);
    wr(1'b0, 2'd0, 16'h0001);                 // E0
    wr(1'b0, 2'd1, 16'h0050);                 // E2, tick on same edge
    rd_chk("wr_over_tick", 1'b0, 2'd1, 16'h0051);
    wr(1'b0, 2'd0, 16'h0000);

    // Two wait states, select held continuously
    @(negedge clk);
    bus_xfer(1'b1, 1'b1, Base + 16'd2, 16'h1234, rd, n);
    check_eq("ws2_wr_lat", 16'(n), 16'd3);
    @(negedge clk);
    tgt = 1'b1; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = Base + 16'd2;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check_eq($sformatf("ws2_ack_%0d", i), 16'(s_ack), (i % 4 == 3) ? 16'h1 : 16'h0);
      check_eq($sformatf("ws2_dat_%0d", i), s_dat, (i % 4 == 3) ? 16'h1234 : 16'h0);
    end
    m_cyc = 1'b0; m_stb = 1'b0;

    // Abort in WAIT by dropping stb
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_dat = 16'hBEEF;
    @(negedge clk);
    m_stb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("abort_ack_%0d", i), 16'(s_ack), 16'h0);
      @(negedge clk);
    end
    m_cyc = 1'b0; m_we = 1'b0;
    rd_chk("abort_no_wr", 1'b1, 2'd2, 16'h1234);

    // Reset in the middle of WAIT
    @(negedge clk);
    tgt = 1'b1; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = Base; m_dat = 16'h0101;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rst_wait_ack", 16'(wb2.ack), 16'h0);
    check_eq("rst_wait_dat", wb2.dat_s2m, 16'h0);
    @(negedge clk);
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_wait_ack2", 16'(wb2.ack), 16'h0);
    rd_chk("rst2_ctrl", 1'b1, 2'd0, 16'h0000);
    rd_chk("rst2_count", 1'b1, 2'd1, 16'h0000);
    rd_chk("rst2_cmp", 1'b1, 2'd2, 16'hFFFF);
    rd_chk("rst2_status", 1'b1, 2'd3, 16'h0000);
    check_eq("rst2_irq", 16'(irq2), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
